count_seq_ctrl: RTL and testbench
=================================

# count_seq_ctrl

Sequencing controller for the team's 4-bit counter datapath. It owns a synchronous counter register and runs it under a start/stop/pause handshake in one-shot or auto-reload mode. It emits a terminal-count pulse and a saturating period tally. It sits between control logic and any block that needs a programmable modulo count; with `limit=15` in auto-reload mode it reproduces a mod-16 counter.

## Interface
- `WIDTH`, default 4: counter and limit width.
- `PCNT_W`, default 8: width of the completed-period tally.

- `clk` — input, 1: single clock; all state updates on its rising edge.
- `reset` — input, 1: asynchronous, active-low; `reset==0` forces reset state immediately.
- `start` — input, 1: sampled in IDLE; begins a run.
- `stop` — input, 1: abort the run; honoured in RUN and HOLD.
- `pause` — input, 1: level; freezes the count while high.
- `mode` — input, 1: 0 = one-shot, 1 = auto-reload; captured at start.
- `limit` — input, WIDTH: terminal count; captured at start.
- `count` — output, WIDTH: current count value.
- `busy` — output, 1: high in RUN and HOLD.
- `done` — output, 1: registered, one-cycle pulse per completed period.
- `err` — output, 1: registered, one-cycle pulse when a start is rejected.
- `periods` — output, PCNT_W: completed periods since last start; saturates at all-ones.

## Operation
- Reset (`reset==0`, async):
  - state = IDLE.
  - `count`, `done`, `err`, `periods`, `busy` = 0.
  - captured `limit_q`, `mode_q` = 0.
- States: IDLE, RUN, HOLD.
- IDLE:
  - `count` held at 0.
  - `start==1` and `limit!=0`: capture `limit_q` and `mode_q`, clear `periods`, go to RUN, keep `count=0`.
  - `start==1` and `limit==0`: stay IDLE, pulse `err`.
  - `stop` and `pause` are ignored.
- RUN, priority order each edge:
  1. `stop==1`: go to IDLE, `count←0`, no `done`, `periods` retained.
  2. `pause==1`: go to HOLD, `count` unchanged.
  3. `count==limit_q`:
     - Always: `count←0`, `done←1`, `periods←periods+1` (saturating).
     - One-shot: go to IDLE.
     - Auto-reload: stay in RUN.
  4. Otherwise: `count←count+1`.
- HOLD:
  - `stop==1`: go to IDLE, `count←0`.
  - `pause==0`: go to RUN with no increment on that edge.
  - Otherwise: hold.
- `start` while `busy` is ignored; it is neither queued nor flagged.
- `limit` and `mode` changes during a run have no effect until the next start.
- Counter arithmetic is modulo 2^WIDTH. Because `limit_q ≤ 2^WIDTH−1` and `count` resets at `limit_q`, no natural overflow occurs.
- `periods` saturates at 2^PCNT_W−1; it never wraps.

## Timing
- `start` sampled at edge k:
  - `busy=1` after edge k, with `count=0`.
  - `count=n` after edge k+n.
  - Edge k+limit+1 returns `count` to 0 and raises `done` for one cycle.
- Period = `limit+1` clocks when no pause occurs.
- Each pause entry costs one frozen cycle plus the cycles `pause` stays high. Exit from HOLD costs one extra cycle.
- One-shot: `busy` falls on the same edge that `done` rises.
- Auto-reload: `done` repeats every `limit+1` cycles, and `busy` stays high.
- Simultaneous events:
  - `stop` with `count==limit_q`: stop wins; no `done`, `periods` unchanged.
  - `pause` with `count==limit_q`: pause wins; `done` is deferred until after resume.
  - `start` with `stop` in IDLE: the run starts and `stop` is ignored.
- Reset assertion mid-run clears everything asynchronously; `done` never fires.
- After reset release, the first active edge may sample `start`.
- `err` and `done` are never high in the same cycle.

## Test plan
- One-shot, `limit=3`, `start` pulse at edge k:
  - `count` after edges k..k+3 = 0,1,2,3.
  - Edge k+4: `done=1`, `busy=0`, `count=0`, `periods=1`.
- Auto-reload, `limit=15`, run 40 cycles:
  - `count` cycles 0..15 (mod-16).
  - `done` pulses at k+16 and k+32.
  - `periods=2`, `busy` stays 1.
- Pause, `limit=5`, `pause` high for 3 cycles after `count=2`:
  - `count` holds at 2 for 4 cycles, resumes at 3.
  - `done` arrives 4 cycles later than the no-pause case.
- `stop` asserted on the edge where `count==limit_q`, `limit=4`:
  - State returns to IDLE, `count=0`, `done` stays 0, `periods=0`.
- Error and ignore cases:
  - `start` with `limit=0`: `err=1` for one cycle, `busy` stays 0.
  - Second `start` mid-run: ignored; `limit_q` unchanged.
- Async reset mid-run:
  - Drive `reset=0` between edges at `count=7`, `periods=3`.
  - Outputs go to 0 without waiting for a clock edge.
  - After `reset=1`, a new `start` behaves as in scenario 1.

Source files
------------

// File: rtl/count_seq_ctrl_if.sv
// rtl/count_seq_ctrl_if.sv - control handshake and status bundle for the counter sequencer
interface count_seq_ctrl_if #(
    parameter int WIDTH  = 4,
    parameter int PCNT_W = 8
);
    logic              start;
    logic              stop;
    logic              pause;
    logic              mode;
    logic [WIDTH-1:0]  limit;
    logic [WIDTH-1:0]  count;
    logic              busy;
    logic              done;
    logic              err;
    logic [PCNT_W-1:0] periods;

    modport master (
        output start, stop, pause, mode, limit,
        input  count, busy, done, err, periods
    );

    modport slave (
        input  start, stop, pause, mode, limit,
        output count, busy, done, err, periods
    );
endinterface

// File: rtl/count_seq_ctrl.sv
// rtl/count_seq_ctrl.sv - start/stop/pause sequencer around a programmable modulo counter
module count_seq_ctrl #(
    parameter int WIDTH  = 4,
    parameter int PCNT_W = 8
) (
    input  logic           clk,
    input  logic           reset,
    count_seq_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [PCNT_W-1:0] PERIODS_MAX = '1;

    state_t           state;
    logic [WIDTH-1:0] limit_q;
    logic             mode_q;

    // Sequencer: state, counter and all status outputs are registered together so
    // done/busy/err change on the same edge as the count they describe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            limit_q     <= '0;
            mode_q      <= 1'b0;
            bus.count   <= '0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.err     <= 1'b0;
            bus.periods <= '0;
        end else begin
            bus.done <= 1'b0;
            bus.err  <= 1'b0;
            case (state)
                IDLE: begin
                    bus.count <= '0;
                    if (bus.start) begin
                        if (bus.limit != '0) begin
                            limit_q     <= bus.limit;
                            mode_q      <= bus.mode;
                            bus.periods <= '0;
                            bus.busy    <= 1'b1;
                            state       <= RUN;
                        end else begin
                            // A zero terminal count would make a degenerate run; refuse it.
                            bus.err <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (bus.stop) begin
                        bus.count <= '0;
                        bus.busy  <= 1'b0;
                        state     <= IDLE;
                    end else if (bus.pause) begin
                        state <= HOLD;
                    end else if (bus.count == limit_q) begin
                        bus.count <= '0;
                        bus.done  <= 1'b1;
                        if (bus.periods != PERIODS_MAX) begin
                            bus.periods <= bus.periods + PCNT_W'(1);
                        end
                        if (!mode_q) begin
                            bus.busy <= 1'b0;
                            state    <= IDLE;
                        end
                    end else begin
                        bus.count <= bus.count + WIDTH'(1);
                    end
                end
                HOLD: begin
                    if (bus.stop) begin
                        bus.count <= '0;
                        bus.busy  <= 1'b0;
                        state     <= IDLE;
                    end else if (!bus.pause) begin
                        // Resume edge only re-enters RUN; counting picks up on the next edge.
                        state <= RUN;
                    end
                end
                default: begin
                    bus.count <= '0;
                    bus.busy  <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_count_seq_ctrl.sv
// tb/tb_count_seq_ctrl.sv - directed bench with reference model for count_seq_ctrl
module tb_count_seq_ctrl;
    logic clk;
    logic reset;

    count_seq_ctrl_if #(.WIDTH(4), .PCNT_W(8)) bus ();

    count_seq_ctrl #(.WIDTH(4), .PCNT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a run is "active" with an optional "frozen" flag; integers throughout.
    bit m_active, m_frozen, m_auto, m_done, m_err;
    int m_cnt, m_lim, m_per;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_active = 0; m_frozen = 0; m_auto = 0; m_done = 0; m_err = 0;
            m_cnt = 0; m_lim = 0; m_per = 0;
        end else begin
            m_done = 0;
            m_err  = 0;
            if (!m_active) begin
                if (bus.start) begin
                    if (int'(bus.limit) == 0) m_err = 1;
                    else begin
                        m_active = 1; m_frozen = 0;
                        m_lim = int'(bus.limit); m_auto = bus.mode;
                        m_per = 0; m_cnt = 0;
                    end
                end
            end else if (bus.stop) begin
                m_active = 0; m_frozen = 0; m_cnt = 0;
            end else if (m_frozen) begin
                if (!bus.pause) m_frozen = 0;
            end else if (bus.pause) begin
                m_frozen = 1;
            end else if (m_cnt == m_lim) begin
                m_cnt = 0;
                m_done = 1;
                if (m_per < 255) m_per = m_per + 1;
                if (!m_auto) m_active = 0;
            end else begin
                m_cnt = (m_cnt + 1) % 16;
            end
        end
    end

    // Compare process: every falling edge, all outputs against the model.
    always @(negedge clk) begin
        check("cmp_count",   32'(bus.count),   32'(m_cnt));
        check("cmp_busy",    32'(bus.busy),    32'(m_active));
        check("cmp_done",    32'(bus.done),    32'(m_done));
        check("cmp_err",     32'(bus.err),     32'(m_err));
        check("cmp_periods", 32'(bus.periods), 32'(m_per));
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic oneshot3(input string tag);
        bus.limit = 4'd3; bus.mode = 1'b0; bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        check({tag, "_busy_k"},  32'(bus.busy),  32'd1);
        check({tag, "_count_k"}, 32'(bus.count), 32'd0);
        for (int i = 1; i <= 3; i++) begin
            tick;
            check({tag, "_count_run"}, 32'(bus.count), 32'(i));
        end
        tick;
        check({tag, "_done"},    32'(bus.done),    32'd1);
        check({tag, "_busy_end"},32'(bus.busy),    32'd0);
        check({tag, "_count_0"}, 32'(bus.count),   32'd0);
        check({tag, "_periods"}, 32'(bus.periods), 32'd1);
        tick;
        check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
        $fatal(1);
    end

    initial begin : stim
        int d1, d2, nd, e;
        bus.start = 0; bus.stop = 0; bus.pause = 0; bus.mode = 0; bus.limit = '0;
        reset = 1'b0;
        repeat (3) tick;
        check("rst_count",   32'(bus.count),   32'd0);
        check("rst_busy",    32'(bus.busy),    32'd0);
        check("rst_periods", 32'(bus.periods), 32'd0);
        reset = 1'b1;

        // One-shot, limit 3
        oneshot3("os");

        // Auto-reload, limit 15, 40 cycles
        bus.limit = 4'd15; bus.mode = 1'b1; bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        d1 = -1; d2 = -1; nd = 0;
        for (int i = 1; i <= 40; i++) begin
            tick;
            if (bus.done) begin
                if (nd == 0) d1 = i;
                else if (nd == 1) d2 = i;
                nd++;
            end
        end
        check("ar_done1_edge", 32'(d1), 32'd16);
        check("ar_done2_edge", 32'(d2), 32'd32);
        check("ar_done_count", 32'(nd), 32'd2);
        check("ar_periods",    32'(bus.periods), 32'd2);
        check("ar_busy",       32'(bus.busy),    32'd1);
        check("ar_count",      32'(bus.count),   32'd8);
        bus.stop = 1'b1;
        tick;
        bus.stop = 1'b0;
        check("ar_stop_busy",    32'(bus.busy),    32'd0);
        check("ar_stop_periods", 32'(bus.periods), 32'd2);

        // Pause, limit 5, one-shot
        bus.limit = 4'd5; bus.mode = 1'b0; bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        tick; tick;
        check("pz_count_pre", 32'(bus.count), 32'd2);
        bus.pause = 1'b1;
        repeat (3) begin
            tick;
            check("pz_count_hold", 32'(bus.count), 32'd2);
        end
        bus.pause = 1'b0;
        tick;
        check("pz_count_exit", 32'(bus.count), 32'd2);
        tick;
        check("pz_count_resume", 32'(bus.count), 32'd3);
        e = 7;
        while (!bus.done && e < 30) begin
            tick;
            e++;
        end
        check("pz_done_edge", 32'(e), 32'd10);

        // Stop coincident with terminal count, limit 4
        bus.limit = 4'd4; bus.mode = 1'b1; bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        repeat (4) tick;
        check("st_count_lim", 32'(bus.count), 32'd4);
        bus.stop = 1'b1;
        tick;
        bus.stop = 1'b0;
        check("st_busy",    32'(bus.busy),    32'd0);
        check("st_count",   32'(bus.count),   32'd0);
        check("st_done",    32'(bus.done),    32'd0);
        check("st_periods", 32'(bus.periods), 32'd0);

        // Start with zero limit
        bus.limit = 4'd0; bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        check("er_err",  32'(bus.err),  32'd1);
        check("er_busy", 32'(bus.busy), 32'd0);
        tick;
        check("er_err_pulse", 32'(bus.err), 32'd0);

        // Second start mid-run is ignored
        bus.limit = 4'd2; bus.mode = 1'b0; bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        tick;
        bus.limit = 4'd7; bus.mode = 1'b1; bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        check("ss_count", 32'(bus.count), 32'd2);
        tick;
        check("ss_done", 32'(bus.done), 32'd1);
        check("ss_busy", 32'(bus.busy), 32'd0);

        // Start together with stop in IDLE
        bus.limit = 4'd1; bus.mode = 1'b0; bus.start = 1'b1; bus.stop = 1'b1;
        tick;
        bus.start = 1'b0; bus.stop = 1'b0;
        check("sx_busy", 32'(bus.busy), 32'd1);
        tick; tick;
        check("sx_done", 32'(bus.done), 32'd1);

        // Async reset mid-run at count 7, periods 3
        bus.limit = 4'd9; bus.mode = 1'b1; bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        repeat (37) tick;
        check("ar9_count",   32'(bus.count),   32'd7);
        check("ar9_periods", 32'(bus.periods), 32'd3);
        #2 reset = 1'b0;
        #1;
        check("ax_count",   32'(bus.count),   32'd0);
        check("ax_busy",    32'(bus.busy),    32'd0);
        check("ax_periods", 32'(bus.periods), 32'd0);
        check("ax_done",    32'(bus.done),    32'd0);
        #2 reset = 1'b1;
        oneshot3("post_rst");

        repeat (2) tick;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
